// File: rtl/lut_config_loader.sv
// Serial MSB-first loader for the split-LUT configuration word; commits with a one-cycle cen strobe.
// Optional even-parity trailer bit is enabled by defining LUT_CFG_PARITY_EN.
module lut_config_loader #(
    parameter int INPUTS    = 4,
    parameter int MEM_SIZE  = 2**INPUTS,
    parameter int CFG_WIDTH = 2*MEM_SIZE
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] config_in,
    output logic                 cen,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CNT_W = $clog2(CFG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
`ifdef LUT_CFG_PARITY_EN
        PARITY,
`endif
        COMMIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CFG_WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0]   cfg_q, cfg_d;
    logic                   xfer;

`ifdef LUT_CFG_PARITY_EN
    logic                   err_q, err_d;
    assign cfg_ready = (state_q == SHIFT) || (state_q == PARITY);
    assign err       = err_q;
`else
    assign cfg_ready = (state_q == SHIFT);
    assign err       = 1'b0;
`endif

    assign xfer      = cfg_valid && cfg_ready;
    assign cen       = (state_q == COMMIT);
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign config_in = cfg_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
`ifdef LUT_CFG_PARITY_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = '0;
                    cnt_d   = '0;
`ifdef LUT_CFG_PARITY_EN
                    err_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    sreg_d = {sreg_q[CFG_WIDTH-2:0], cfg_bit};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef LUT_CFG_PARITY_EN
                        state_d = PARITY;
`else
                        // Commit the word including the bit arriving on this edge.
                        cfg_d   = {sreg_q[CFG_WIDTH-2:0], cfg_bit};
                        state_d = COMMIT;
`endif
                    end
                end
            end
`ifdef LUT_CFG_PARITY_EN
            PARITY: begin
                if (xfer) begin
                    if ((^sreg_q ^ cfg_bit) == 1'b0) begin
                        cfg_d   = sreg_q;
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            COMMIT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
`ifdef LUT_CFG_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
`ifdef LUT_CFG_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: reset, contiguous/stalled loads, ignored start, mid-load reset, parity.
module tb_lut_config_loader;
    localparam int W = 32;
`ifdef LUT_CFG_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic          cclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  config_in;
    logic          cen;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int cen_count = 0;
    int cen_before = 0;

    lut_config_loader dut (
        .cclk      (cclk),
        .rst       (rst),
        .start     (start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .config_in (config_in),
        .cen       (cen),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) cyc <= cyc + 1;
    always @(negedge cclk) if (cen === 1'b1) cen_count++;

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        check("ready_after_start", {31'd0, cfg_ready}, 32'd1);
    endtask

    // Sends nbits of w MSB first; start_at raises start alongside that bit index.
    task automatic send_word(input logic [31:0] w, input int nbits, input bit stall,
                             input int start_at, input logic pbit);
        for (int i = 0; i < nbits; i++) begin
            if (stall && i > 0) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom);
                step();
            end
            cfg_valid = 1'b1;
            cfg_bit   = w[W-1-i];
            start     = (i == start_at);
            step();
            start = 1'b0;
        end
        if (nbits == W && PBITS == 1) begin
            cfg_valid = 1'b1;
            cfg_bit   = pbit;
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic finish_load(input string tag, input logic [31:0] w, input int lat);
        $display("load %s: word=%h latency=%0d config_in=%h cen=%b", tag, w, cyc - start_cyc, config_in, cen);
        check({tag, "_cen"}, {31'd0, cen}, 32'd1);
        check({tag, "_latency"}, cyc - start_cyc, lat);
        check({tag, "_config"}, config_in, w);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        step();
        check({tag, "_cen_width"}, {31'd0, cen}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        step();
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_cen_count"}, cen_count - cen_before, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start     = 1'($urandom);
            cfg_valid = 1'($urandom);
            cfg_bit   = 1'($urandom);
            step();
        end
        $display("reset: config_in=%h cen=%b busy=%b done=%b err=%b ready=%b", config_in, cen, busy, done, err, cfg_ready);
        check("rst_config", config_in, 32'd0);
        check("rst_outs", {27'd0, cen, busy, done, err, cfg_ready}, 32'd0);
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        step();
        check("idle_ready", {31'd0, cfg_ready}, 32'd0);

        // Basic contiguous load
        cen_before = cen_count;
        begin_load();
        send_word(32'hA5A50F0F, W, 1'b0, -1, 1'b0);
        check("basic_hi_half", {16'd0, config_in[31:16]}, 32'h0000A5A5);
        check("basic_lo_half", {16'd0, config_in[15:0]}, 32'h00000F0F);
        finish_load("basic", 32'hA5A50F0F, W + PBITS);

        // Back-to-back stalled load: gap after every accepted bit
        cen_before = cen_count;
        begin_load();
        send_word(32'hA5A50F0F, W, 1'b1, -1, 1'b0);
        finish_load("stall", 32'hA5A50F0F, W + PBITS + 31);

        // Start pulsed during SHIFT at bit 10 must be ignored
        cen_before = cen_count;
        begin_load();
        send_word(32'h3C96E1D2, W, 1'b0, 10, 1'b0);
        finish_load("ign_start", 32'h3C96E1D2, W + PBITS);

        // Reset after 20 bits of a load
        cen_before = cen_count;
        begin_load();
        send_word(32'hFFFFFFFF, 20, 1'b0, -1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start     = 1'($urandom);
            cfg_valid = 1'($urandom);
            step();
        end
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        step();
        step();
        $display("midreset: config_in=%h busy=%b cen_pulses=%0d", config_in, busy, cen_count - cen_before);
        check("midrst_config", config_in, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_no_cen", cen_count - cen_before, 32'd0);

        cen_before = cen_count;
        begin_load();
        send_word(32'h12345678, W, 1'b0, -1, 1'b0);
        finish_load("after_rst", 32'h12345678, W + PBITS);

`ifdef LUT_CFG_PARITY_EN
        // Good parity commits, bad parity sets err and leaves config_in alone
        cen_before = cen_count;
        begin_load();
        send_word(32'h00000001, W, 1'b0, -1, 1'b1);
        finish_load("par_good", 32'h00000001, W + 1);

        cen_before = cen_count;
        begin_load();
        send_word(32'h00000001, W, 1'b0, -1, 1'b0);
        $display("par_bad: err=%b cen=%b busy=%b config_in=%h", err, cen, busy, config_in);
        check("par_bad_err", {31'd0, err}, 32'd1);
        check("par_bad_cen", {31'd0, cen}, 32'd0);
        check("par_bad_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("par_bad_done", {31'd0, done}, 32'd0);
        check("par_bad_sticky", {31'd0, err}, 32'd1);
        check("par_bad_config", config_in, 32'h00000001);
        check("par_bad_no_cen", cen_count - cen_before, 32'd0);
        begin_load();
        check("par_err_cleared", {31'd0, err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
